// File: rtl/alu_reg_seq.sv
// alu_reg_seq: control-side sequencer for the register-file/ALU datapath.
// Accepts MIPS R-type words over a valid/ready handshake, decodes them,
// drives addresses/ALU_OP/Write_Reg for one EXEC cycle and reports completion.
// Optional feature macro: ALU_REG_SEQ_OF_GUARD_EN (suppress writeback of an
// overflowing add/sub and flag it as Illegal).
module alu_reg_seq #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      Inst,
    input  logic             Inst_Valid,
    output logic             Inst_Ready,
    output logic [4:0]       R_Addr_A,
    output logic [4:0]       R_Addr_B,
    output logic [4:0]       W_Addr,
    output logic             Write_Reg,
    output logic [2:0]       ALU_OP,
    input  logic             ZF,
    input  logic             OF,
    output logic             Done,
    output logic             Illegal,
    output logic             Flag_ZF,
    output logic             Flag_OF,
    output logic [CNT_W-1:0] Inst_Count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      inst_q, inst_d;
    logic [4:0]       ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
    logic [2:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic             zf_q, zf_d, of_q, of_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             legal_dec;
    logic [2:0]       op_dec;
    logic             ovf_block;
    logic [4:0]       shamt_unused;

    // shamt is not used by any supported operation
    assign shamt_unused = inst_q[10:6];

    // Decode the latched word: opcode must be SPECIAL and funct from the supported set
    always_comb begin
        legal_dec = 1'b0;
        op_dec    = 3'b000;
        if (inst_q[31:26] == 6'b000000) begin
            legal_dec = 1'b1;
            case (inst_q[5:0])
                6'b100100: op_dec = 3'b000;
                6'b100101: op_dec = 3'b001;
                6'b100110: op_dec = 3'b010;
                6'b100111: op_dec = 3'b011;
                6'b100000: op_dec = 3'b100;
                6'b100010: op_dec = 3'b101;
                6'b101010: op_dec = 3'b110;
                6'b000100: op_dec = 3'b111;
                default:   legal_dec = 1'b0;
            endcase
        end
    end

`ifdef ALU_REG_SEQ_OF_GUARD_EN
    // An overflowing add/sub must not reach the register file
    assign ovf_block = ((op_q == 3'b100) || (op_q == 3'b101)) && OF;
`else
    assign ovf_block = 1'b0;
`endif

    // Next-state and register updates for each FSM phase
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        wa_d      = wa_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        zf_d      = zf_q;
        of_d      = of_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (Inst_Valid) begin
                    inst_d  = Inst;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ra_d = inst_q[25:21];
                rb_d = inst_q[20:16];
                wa_d = inst_q[15:11];
                if (legal_dec) begin
                    op_d      = op_dec;
                    illegal_d = 1'b0;
                    state_d   = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_EXEC: begin
                zf_d      = ZF;
                of_d      = OF;
                cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                illegal_d = ovf_block;
                state_d   = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath-control registers; async active-low reset discards any pending work
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            inst_q    <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            wa_q      <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            wa_q      <= wa_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            zf_q      <= zf_d;
            of_q      <= of_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs: strobes decoded from state so reset removes them immediately
    always_comb begin
        Inst_Ready = (state_q == S_IDLE);
        Write_Reg  = (state_q == S_EXEC) && (wa_q != 5'd0) && !ovf_block;
        Done       = (state_q == S_DONE);
        Illegal    = (state_q == S_DONE) && illegal_q;
        R_Addr_A   = ra_q;
        R_Addr_B   = rb_q;
        W_Addr     = wa_q;
        ALU_OP     = op_q;
        Flag_ZF    = zf_q;
        Flag_OF    = of_q;
        Inst_Count = cnt_q;
    end

endmodule

// File: tb/tb_alu_reg_seq.sv
// Testbench for alu_reg_seq: directed and random R-type traffic against a
// behavioural model of the decode table, write rules, flags and counter.
module tb_alu_reg_seq;

    localparam int CNT_W = 2;
`ifdef ALU_REG_SEQ_OF_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset;
    logic [31:0]      Inst;
    logic             Inst_Valid;
    logic             Inst_Ready;
    logic [4:0]       R_Addr_A, R_Addr_B, W_Addr;
    logic             Write_Reg;
    logic [2:0]       ALU_OP;
    logic             ZF, OF;
    logic             Done, Illegal, Flag_ZF, Flag_OF;
    logic [CNT_W-1:0] Inst_Count;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;
    bit m_zf = 1'b0;
    bit m_of = 1'b0;

    alu_reg_seq #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Inst(Inst), .Inst_Valid(Inst_Valid),
        .Inst_Ready(Inst_Ready), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .W_Addr(W_Addr), .Write_Reg(Write_Reg), .ALU_OP(ALU_OP),
        .ZF(ZF), .OF(OF), .Done(Done), .Illegal(Illegal),
        .Flag_ZF(Flag_ZF), .Flag_OF(Flag_OF), .Inst_Count(Inst_Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference decode: supported R-type funct codes and their ALU operation
    function automatic void ref_decode(input logic [31:0] w, output bit legal, output logic [2:0] op);
        logic [5:0] fn_tab [8] = '{6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                   6'b100000, 6'b100010, 6'b101010, 6'b000100};
        legal = 1'b0;
        op    = 3'b000;
        if (w[31:26] == 6'd0)
            for (int k = 0; k < 8; k++)
                if (w[5:0] == fn_tab[k]) begin
                    legal = 1'b1;
                    op    = 3'(k);
                end
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        rtype = {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic model_reset();
        model_cnt = 0;
        m_zf = 1'b0;
        m_of = 1'b0;
    endtask

    // One full transaction from IDLE back to IDLE, checked phase by phase
    task automatic do_inst(input logic [31:0] w, input bit f_zf, input bit f_of,
                           input bit hold, input logic [31:0] nxt);
        bit         legal, wr, ill;
        logic [2:0] op;
        ref_decode(w, legal, op);
        Inst = w;
        Inst_Valid = 1'b1;
        chk("ready_idle", Inst_Ready, 1);
        tick();
        Inst_Valid = 1'b0;
        Inst = $urandom;
        ZF = 1'($urandom);
        OF = 1'($urandom);
        chk("ready_decode", Inst_Ready, 0);
        chk("wr_decode", Write_Reg, 0);
        chk("done_decode", Done, 0);
        tick();
        if (legal) begin
            ill = GUARD && f_of && (op == 3'b100 || op == 3'b101);
            wr  = (w[15:11] != 5'd0) && !ill;
            ZF = f_zf;
            OF = f_of;
            #1;
            chk("exec_ra", R_Addr_A, w[25:21]);
            chk("exec_rb", R_Addr_B, w[20:16]);
            chk("exec_wa", W_Addr, w[15:11]);
            chk("exec_op", ALU_OP, op);
            chk("exec_wr", Write_Reg, wr);
            chk("exec_done", Done, 0);
            tick();
            ZF = 1'($urandom);
            OF = 1'($urandom);
            m_zf = f_zf;
            m_of = f_of;
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
        end else begin
            ill = 1'b1;
        end
        chk("done_pulse", Done, 1);
        chk("done_illegal", Illegal, ill);
        chk("done_wr", Write_Reg, 0);
        chk("done_ra", R_Addr_A, w[25:21]);
        chk("done_wa", W_Addr, w[15:11]);
        chk("flag_zf", Flag_ZF, m_zf);
        chk("flag_of", Flag_OF, m_of);
        chk("count", Inst_Count, model_cnt);
        if (hold) begin
            Inst = nxt;
            Inst_Valid = 1'b1;
        end
        tick();
        chk("ready_back", Inst_Ready, 1);
        chk("done_clear", Done, 0);
        chk("illegal_clear", Illegal, 0);
    endtask

    task automatic pulse_reset();
        Reset = 1'b0;
        Inst_Valid = 1'b0;
        tick();
        Reset = 1'b1;
        model_reset();
        tick();
    endtask

    initial begin
        logic [5:0]  legal_fn [8] = '{6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                      6'b100000, 6'b100010, 6'b101010, 6'b000100};
        logic [31:0] w;
        int          sel;

        // Reset held low with random inputs
        Reset = 1'b0;
        Inst = $urandom;
        Inst_Valid = 1'b1;
        ZF = 1'b1;
        OF = 1'b1;
        #2;
        tick();
        tick();
        chk("rst_ready", Inst_Ready, 1);
        chk("rst_wr", Write_Reg, 0);
        chk("rst_done", Done, 0);
        chk("rst_illegal", Illegal, 0);
        chk("rst_fzf", Flag_ZF, 0);
        chk("rst_fof", Flag_OF, 0);
        chk("rst_ra", R_Addr_A, 0);
        chk("rst_rb", R_Addr_B, 0);
        chk("rst_wa", W_Addr, 0);
        chk("rst_op", ALU_OP, 0);
        chk("rst_cnt", Inst_Count, 0);

        // Release with no traffic: stay idle, never write
        Inst_Valid = 1'b0;
        Reset = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ready", Inst_Ready, 1);
            chk("idle_wr", Write_Reg, 0);
        end

        // Reset asserted in the middle of EXEC
        Inst = 32'h0022_1820;
        Inst_Valid = 1'b1;
        tick();
        Inst_Valid = 1'b0;
        tick();
        chk("mid_exec_wr", Write_Reg, 1);
        ZF = 1'b1;
        OF = 1'b1;
        Reset = 1'b0;
        #1;
        chk("mid_rst_wr", Write_Reg, 0);
        chk("mid_rst_ready", Inst_Ready, 1);
        tick();
        Reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_done", Done, 0);
            chk("mid_rst_cnt", Inst_Count, 0);
            chk("mid_rst_fzf", Flag_ZF, 0);
            chk("mid_rst_fof", Flag_OF, 0);
        end

        // Directed cases
        do_inst(32'h0022_1820, 1'b0, 1'b0, 1'b0, 32'h0);
        do_inst(32'h8C22_0000, 1'b1, 1'b1, 1'b0, 32'h0);
        do_inst(32'h0020_0008, 1'b1, 1'b0, 1'b0, 32'h0);
        do_inst(32'h0022_0024, 1'b1, 1'b0, 1'b1, 32'h0022_1822);
        do_inst(32'h0022_1822, 1'b0, 1'b1, 1'b0, 32'h0);
        do_inst(32'h0022_1820, 1'b0, 1'b1, 1'b0, 32'h0);

        // Counter wrap: five legal instructions from zero
        pulse_reset();
        for (int i = 0; i < 5; i++)
            do_inst(rtype(5'(i), 5'(i + 1), 5'(i + 2), 6'b100101), 1'(i), 1'b0, 1'b0, 32'h0);
        chk("wrap_cnt", Inst_Count, 1);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            w = $urandom;
            if (sel == 1)
                w[31:26] = 6'd0;
            else if (sel >= 2)
                w = rtype(5'($urandom), 5'($urandom), 5'($urandom), legal_fn[$urandom_range(0, 7)]);
            else if (w[31:26] == 6'd0)
                w[31:26] = 6'b100011;
            do_inst(w, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), w);
            Inst_Valid = 1'b0;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                chk("gap_wr", Write_Reg, 0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a hung sequence
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_reg_seq.md
Name: alu_reg_seq

Overview:
- Instruction sequencer that drives the register-file/ALU datapath from the control side.
- Accepts MIPS R-type instruction words over a valid/ready handshake and decodes rs/rt/rd/funct.
- Drives R_Addr_A, R_Addr_B, W_Addr, ALU_OP and a one-cycle Write_Reg into the datapath, captures the returned ZF/OF, and reports completion.
- Sits between the instruction source (switches or test bench) and the register/ALU datapath.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Inst  input  32  instruction word; sampled when Inst_Valid && Inst_Ready.
- Inst_Valid  input  1  source holds Inst valid.
- Inst_Ready  output  1  sequencer can accept an instruction (IDLE only).
- R_Addr_A  output  5  register-file read address A (rs).
- R_Addr_B  output  5  register-file read address B (rt).
- W_Addr  output  5  register-file write address (rd).
- Write_Reg  output  1  register write enable to the datapath.
- ALU_OP  output  3  ALU operation select.
- ZF  input  1  ALU zero flag from the datapath.
- OF  input  1  ALU overflow flag from the datapath.
- Done  output  1  one-cycle completion pulse.
- Illegal  output  1  set with Done when the instruction was not executed.
- Flag_ZF  output  1  ZF captured in EXEC.
- Flag_OF  output  1  OF captured in EXEC.
- Inst_Count  output  CNT_W  count of executed (legal) instructions.

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-low. Reset=0 forces IDLE at once, independent of Clk.
- Reset values: Inst_Ready=1, Write_Reg=0, Done=0, Illegal=0, Flag_ZF=0, Flag_OF=0, R_Addr_A=R_Addr_B=W_Addr=0, ALU_OP=000, Inst_Count=0.
- FSM states: IDLE -> DECODE -> EXEC -> DONE -> IDLE, or IDLE -> DECODE -> DONE for an illegal instruction.
- IDLE:
  - Inst_Ready=1.
  - On a Clk edge with Inst_Valid=1, latch Inst and go to DECODE.
  - Inst_Valid=0 keeps the FSM in IDLE.
- DECODE:
  - Inst_Ready=0.
  - Load R_Addr_A=Inst[25:21], R_Addr_B=Inst[20:16], W_Addr=Inst[15:11].
  - Legal requires opcode Inst[31:26]=000000 and a funct from the table below. Legal goes to EXEC; otherwise go to DONE with Illegal pending.
- funct -> ALU_OP:
  - 100100 and -> 000
  - 100101 or -> 001
  - 100110 xor -> 010
  - 100111 nor -> 011
  - 100000 add -> 100
  - 100010 sub -> 101
  - 101010 slt -> 110
  - 000100 sllv -> 111
- EXEC (exactly 1 cycle):
  - Addresses and ALU_OP stable for the whole cycle.
  - Write_Reg=1 unless W_Addr=0 (register 0 is never written).
  - Datapath writes on the Clk edge that ends EXEC.
  - On that same edge, Flag_ZF<=ZF, Flag_OF<=OF, and Inst_Count<=Inst_Count+1, wrapping modulo 2^CNT_W.
- DONE (1 cycle):
  - Done=1.
  - Illegal=1 only if DECODE rejected the instruction; flags and counter are unchanged in that case.
  - Next state is IDLE.
- Write_Reg is 0 in every state except EXEC.
- Addresses and ALU_OP hold their last values outside EXEC.
- Flag_ZF and Flag_OF hold until the next EXEC.
- Latency, counted in edges after the accept edge: DECODE at edge 0, EXEC at edge 1, DONE at edge 2, Inst_Ready=1 again after edge 3. Throughput is one instruction per 4 cycles.
- Inst_Valid held high across DONE: the next instruction is accepted on the first IDLE edge, with no extra bubble.
- Reset mid-EXEC: Write_Reg drops at once, no flag or counter update, and the pending instruction is discarded.

Optional Feature:
- Macro: ALU_REG_SEQ_OF_GUARD_EN.
- Defined: in EXEC, for ALU_OP 100 or 101, Write_Reg = (W_Addr!=0) && !OF. An overflowing add or sub leaves rd unchanged. Flag_OF is still captured, and Illegal=1 is raised in DONE. Inst_Count still increments.
- Undefined: OF never gates Write_Reg, and Illegal depends only on decode.

Test Plan:
- Reset and idle: Reset=0 with random inputs -> all outputs at reset values. Release Reset with Inst_Valid=0 for 10 cycles -> Inst_Ready=1, Write_Reg never 1.
- Legal add: Inst=0x00221820 (add $3,$1,$2) -> after DECODE, R_Addr_A=1, R_Addr_B=2, W_Addr=3, ALU_OP=100. Write_Reg=1 for exactly 1 cycle, Done pulses 2 edges after accept, Inst_Count=1.
- Illegal instruction: Inst=0x8C220000 (lw) -> no Write_Reg, Done=1 with Illegal=1, Inst_Count unchanged. Same for funct 001000.
- rd=0 and back-to-back: Inst=0x00220024 (and $0) -> Write_Reg stays 0 and Inst_Count increments. Then hold Inst_Valid high with sub 0x00221822 -> accepted on the first IDLE edge, ALU_OP=101.
- Flags and guard: drive OF=1 in EXEC of an add -> Flag_OF=1. With ALU_REG_SEQ_OF_GUARD_EN defined, Write_Reg=0 and Illegal=1; without it, Write_Reg=1 and Illegal=0.
- Reset mid-EXEC and counter wrap: assert Reset=0 during EXEC -> Write_Reg=0 immediately and Inst_Count unchanged. With CNT_W=2, five legal instructions -> Inst_Count=1.
